// File: rtl/retire_trace_if.sv
// Commit-tap, trace-drain and status bundle between the cpu-side environment and
// the retire trace buffer. 'slave' is the monitor's view; 'master' is the environment's view.
interface retire_trace_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int REG_W  = 4,
  parameter int CNT_W  = 32
);
  localparam int REC_W = CNT_W + 4 + REG_W + 2*DATA_W + ADDR_W;

  // MEM/WB commit tap
  logic              en;
  logic              reg_we;
  logic [REG_W-1:0]  reg_dst;
  logic [DATA_W-1:0] reg_data;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              halt;

  // Trace drain port
  logic              trace_valid;
  logic              trace_ready;
  logic [REC_W-1:0]  trace_rec;

  // Statistics and run status
  logic [CNT_W-1:0]  inst_count;
  logic [CNT_W-1:0]  cycle_count;
  logic [CNT_W-1:0]  drop_count;
  logic              done;
  logic              timeout;
  logic              overflow;
  logic              proto_err;

  modport slave (
    input  en, reg_we, reg_dst, reg_data, mem_rd, mem_wr, mem_addr, mem_data, halt,
    input  trace_ready,
    output trace_valid, trace_rec,
    output inst_count, cycle_count, drop_count, done, timeout, overflow, proto_err
  );

  modport master (
    output en, reg_we, reg_dst, reg_data, mem_rd, mem_wr, mem_addr, mem_data, halt,
    output trace_ready,
    input  trace_valid, trace_rec,
    input  inst_count, cycle_count, drop_count, done, timeout, overflow, proto_err
  );
endinterface

// File: rtl/retire_trace_buffer.sv
// Retire monitor: packs one trace record per commit cycle into a DEPTH-entry FIFO,
// keeps saturating run statistics and runs a halt/watchdog RUN->DRAIN->DONE FSM.
module retire_trace_buffer #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int REG_W       = 4,
  parameter int DEPTH       = 16,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 100000
) (
  input  logic           clk,
  input  logic           rst,
  retire_trace_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = CNT_W + 4 + REG_W + 2*DATA_W + ADDR_W;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_inst;
  logic [CNT_W-1:0] r_drop;
  logic             r_timeout;
  logic             r_overflow;
  logic             r_proto_err;
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [REC_W-1:0] r_mem [DEPTH];

  logic             w_sample;
  logic             w_both;
  logic             w_commit;
  logic             w_retire;
  logic [CNT_W-1:0] w_cycle_inc;
  logic             w_wdog;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [REC_W-1:0] w_rec;

  assign w_sample    = (r_state == S_RUN) & bus.en;
  assign w_both      = bus.mem_rd & bus.mem_wr;
  // A conflicting rd+wr carries no memory op, so it only commits alongside reg_we/halt
  assign w_commit    = w_sample & (bus.reg_we | bus.halt | (bus.mem_rd ^ bus.mem_wr));
  assign w_retire    = w_sample & (bus.halt | bus.reg_we | (bus.mem_wr & ~bus.mem_rd));
  assign w_cycle_inc = sat_inc(r_cycle);
  assign w_wdog      = w_sample & (w_cycle_inc >= LIMIT);

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = ~w_empty & bus.trace_ready;
  // A same-cycle pop frees the head slot, so a full FIFO still accepts the push
  assign w_push  = w_commit & (~w_full | w_pop);
  assign w_drop  = w_commit & w_full & ~w_pop;

  assign w_rec = {w_cycle_inc,
                  bus.halt,
                  bus.mem_wr & ~w_both,
                  bus.mem_rd & ~w_both,
                  bus.reg_we,
                  bus.reg_dst,
                  bus.reg_data,
                  bus.mem_addr,
                  bus.mem_data};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (w_sample && (bus.halt || w_wdog)) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_empty) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_DONE;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_cycle     <= '0;
      r_inst      <= '0;
      r_drop      <= '0;
      r_timeout   <= 1'b0;
      r_overflow  <= 1'b0;
      r_proto_err <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_sample) r_cycle <= w_cycle_inc;
      if (w_retire) r_inst  <= sat_inc(r_inst);
      if (w_drop) begin
        r_drop     <= sat_inc(r_drop);
        r_overflow <= 1'b1;
      end
      if (w_wdog) r_timeout <= 1'b1;
      if (w_sample && w_both) r_proto_err <= 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Record storage is data only; pointer reset alone empties the FIFO
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_rec;
  end

  assign bus.trace_valid = ~w_empty;
  assign bus.trace_rec   = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign bus.inst_count  = r_inst;
  assign bus.cycle_count = r_cycle;
  assign bus.drop_count  = r_drop;
  assign bus.done        = (r_state == S_DONE);
  assign bus.timeout     = r_timeout;
  assign bus.overflow    = r_overflow;
  assign bus.proto_err   = r_proto_err;
endmodule
